mem_arbiter: RTL and testbench

- Shares the single-port unified memory between the instruction-fetch requester and the load/store requester of the core.
- Sits between the core and the memory instance. Drives the memory's address, write-data and write-enable, and captures its asynchronous read data.
- Arbitrates round-robin, registers each access, and performs read-modify-write for byte and halfword stores. The memory itself supports only word writes.

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and constants for the unified-memory arbiter.
//   - state_t    : arbiter FSM states
//   - REQ_IF/REQ_D: requester ids (fetch / load-store)
//   - STRB_FULL  : byte-strobe value that denotes a whole-word store
//   - byte_merge : per-lane select between new store data and old memory word
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        MERGE_WR = 2'd2,
        RESP     = 2'd3
    } state_t;

    localparam logic       REQ_IF    = 1'b0;
    localparam logic       REQ_D     = 1'b1;
    localparam logic [3:0] STRB_FULL = 4'b1111;

    // Lanes with strb set take the store data, the rest keep the old word.
    function automatic logic [31:0] byte_merge(input logic [31:0] wdata,
                                               input logic [31:0] old,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = strb[i] ? wdata[8*i +: 8] : old[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Round-robin arbiter sharing a single-port, word-write-only memory between
//   the instruction-fetch requester and the load/store requester. Each access
//   is latched at grant; byte/halfword stores are done as read-modify-write.
//
// Ports:
//   clk, reset                 rising-edge clock, async active-high reset
//   if_req/if_addr             fetch request (read only) and byte address
//   if_ack/if_rdata            one-cycle completion pulse and fetched word
//   d_req/d_we/d_addr          data request, 1=store, byte address
//   d_wdata/d_strb             lane-aligned store data and byte enables
//   d_ack/d_rdata              one-cycle completion pulse and load data
//   mem_address/mem_data_in    memory address and write data
//   mem_data_out               memory combinational read data
//   mem_we                     memory write enable (write at clk edge)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter bit RESET_PRIO = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [3:0]    d_strb,
    output logic          d_ack,
    output logic [31:0]   d_rdata,
    output logic [AW-1:0] mem_address,
    output logic [31:0]   mem_data_in,
    input  logic [31:0]   mem_data_out,
    output logic          mem_we
);

    state_t        state;
    logic          rr_last;    // requester served most recently
    logic          win_q;      // requester owning the current access
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    strb_q;
    logic [31:0]   merged_q;

    logic grant_d;
    logic partial_q;
    logic to_resp;

    // Data wins when it is alone, or on a tie when fetch was served last.
    assign grant_d   = d_req && (!if_req || (rr_last == REQ_IF));
    assign partial_q = we_q && (strb_q != STRB_FULL) && (strb_q != 4'b0000);
    assign to_resp   = ((state == ACCESS) && !partial_q) || (state == MERGE_WR);

    // Write enable depends only on state and the latched access type, so it
    // can never be raised in IDLE or RESP and drops immediately on reset.
    assign mem_we = ((state == ACCESS) && we_q && (strb_q == STRB_FULL)) ||
                    (state == MERGE_WR);

    always_comb begin
        mem_data_in = '0;
        if (state == MERGE_WR) begin
            mem_data_in = merged_q;
        end else if (mem_we) begin
            mem_data_in = wdata_q;
        end
    end

    assign mem_address = addr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr_last  <= RESET_PRIO ? REQ_IF : REQ_D;
            win_q    <= REQ_IF;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
            merged_q <= '0;
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            // Acks are registered: they rise in the cycle the FSM sits in RESP.
            if_ack <= to_resp && (win_q == REQ_IF);
            d_ack  <= to_resp && (win_q == REQ_D);

            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        if (grant_d) begin
                            win_q   <= REQ_D;
                            rr_last <= REQ_D;
                            addr_q  <= d_addr;
                            we_q    <= d_we;
                            wdata_q <= d_wdata;
                            strb_q  <= d_strb;
                        end else begin
                            win_q   <= REQ_IF;
                            rr_last <= REQ_IF;
                            addr_q  <= if_addr;
                            we_q    <= 1'b0;
                            wdata_q <= '0;
                            strb_q  <= '0;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        if (win_q == REQ_D) begin
                            d_rdata <= mem_data_out;
                        end else begin
                            if_rdata <= mem_data_out;
                        end
                        state <= RESP;
                    end else if (partial_q) begin
                        merged_q <= byte_merge(wdata_q, mem_data_out, strb_q);
                        state    <= MERGE_WR;
                    end else begin
                        // Full store is written at this edge; empty strobe writes nothing.
                        state <= RESP;
                    end
                end
                MERGE_WR: state <= RESP;
                RESP:     state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a small word-addressed memory model.
module tb_mem_arbiter;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ack;
    logic [31:0]   if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [31:0]   d_wdata = '0;
    logic [3:0]    d_strb = '0;
    logic          d_ack;
    logic [31:0]   d_rdata;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_data_in;
    logic [31:0]   mem_data_out;
    logic          mem_we;

    logic [31:0] mem [0:63];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .RESET_PRIO(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_ack       (if_ack),
        .if_rdata     (if_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_strb       (d_strb),
        .d_ack        (d_ack),
        .d_rdata      (d_rdata),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_we       (mem_we)
    );

    assign mem_data_out = mem[mem_address[7:2]];

    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_val;
        else if (mem_we) mem[mem_address[7:2]] <= mem_data_in;
    end

    // Issues one access and observes it cycle by cycle; cycle 0 is the IDLE
    // sampling cycle. lat=-1 means no ack within the budget.
    task automatic run_access(input bit is_fetch, input bit we, input logic [AW-1:0] addr,
                              input logic [31:0] wdata, input logic [3:0] strb,
                              output int lat, output logic [31:0] rdata,
                              output int we_cnt, output int we_off,
                              output logic [31:0] we_data, output logic [AW-1:0] we_addr,
                              output bit other_ack);
        lat = -1; rdata = '0; we_cnt = 0; we_off = -1; we_data = '0; we_addr = '0; other_ack = 1'b0;
        @(posedge clk); #1;
        if (is_fetch) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_strb = strb;
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (mem_we) begin
                we_cnt++; we_off = cyc; we_data = mem_data_in; we_addr = mem_address;
            end
            if (is_fetch ? d_ack : if_ack) other_ack = 1'b1;
            if (is_fetch ? if_ack : d_ack) begin
                lat = cyc;
                rdata = is_fetch ? if_rdata : d_rdata;
                break;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_reset();
        pre_en = 1'b1; pre_idx = 6'd4; pre_val = 32'h11223344;
        @(posedge clk); #1;
        pre_idx = 6'd12; pre_val = 32'h55667788;
        @(posedge clk); #1;
        pre_en = 1'b0;
        total++; if (if_ack !== 1'b0) begin bad++; $display("FAIL reset_if_ack: got %b want 0", if_ack); end
        total++; if (d_ack !== 1'b0) begin bad++; $display("FAIL reset_d_ack: got %b want 0", d_ack); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        total++; if (mem_address !== '0) begin bad++; $display("FAIL reset_mem_address: got %h want 0", mem_address); end
        total++; if (mem_data_in !== '0) begin bad++; $display("FAIL reset_mem_data_in: got %h want 0", mem_data_in); end
        total++; if (if_rdata !== '0) begin bad++; $display("FAIL reset_if_rdata: got %h want 0", if_rdata); end
        total++; if (d_rdata !== '0) begin bad++; $display("FAIL reset_d_rdata: got %h want 0", d_rdata); end
    endtask

    // Must run straight after reset release so the first tie is fresh.
    task automatic test_round_robin();
        int n = 0;
        int ack_cyc [4];
        bit ack_d [4];
        int exp_cyc [4] = '{2, 5, 8, 11};
        bit exp_d [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin ack_cyc[i] = -1; ack_d[i] = 1'b0; end
        @(posedge clk); #1;
        reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h0000_0000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0010; d_strb = 4'b0000;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if ((d_ack || if_ack) && n < 4) begin
                ack_cyc[n] = cyc; ack_d[n] = d_ack; n++;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (ack_d[i] !== exp_d[i]) begin
                bad++; $display("FAIL rr_order[%0d]: got d=%b want d=%b", i, ack_d[i], exp_d[i]);
            end
            total++;
            if (ack_cyc[i] != exp_cyc[i]) begin
                bad++; $display("FAIL rr_cycle[%0d]: got %0d want %0d", i, ack_cyc[i], exp_cyc[i]);
            end
        end
    endtask

    task automatic test_load();
        int lat, wc, wo; logic [31:0] rd, wd; logic [AW-1:0] wa; bit oth;
        run_access(1'b0, 1'b0, 32'h10, '0, 4'b0000, lat, rd, wc, wo, wd, wa, oth);
        total++; if (lat != 2) begin bad++; $display("FAIL load_latency: got %0d want 2", lat); end
        total++; if (rd !== 32'h11223344) begin bad++; $display("FAIL load_rdata: got %h want 11223344", rd); end
        total++; if (oth !== 1'b0) begin bad++; $display("FAIL load_if_ack: got %b want 0", oth); end
        total++; if (wc != 0) begin bad++; $display("FAIL load_mem_we: got %0d cycles want 0", wc); end
    endtask

    task automatic test_partial_store();
        int lat, wc, wo; logic [31:0] rd, wd; logic [AW-1:0] wa; bit oth;
        run_access(1'b0, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0010, lat, rd, wc, wo, wd, wa, oth);
        total++; if (wc != 1) begin bad++; $display("FAIL pstore_we_count: got %0d want 1", wc); end
        total++; if (wo != 2) begin bad++; $display("FAIL pstore_we_cycle: got %0d want 2", wo); end
        total++; if (wd !== 32'h1122CC44) begin bad++; $display("FAIL pstore_data: got %h want 1122cc44", wd); end
        total++; if (lat != 3) begin bad++; $display("FAIL pstore_latency: got %0d want 3", lat); end
        run_access(1'b0, 1'b0, 32'h10, '0, 4'b0000, lat, rd, wc, wo, wd, wa, oth);
        total++; if (rd !== 32'h1122CC44) begin bad++; $display("FAIL pstore_readback: got %h want 1122cc44", rd); end
    endtask

    task automatic test_full_store();
        int lat, wc, wo; logic [31:0] rd, wd; logic [AW-1:0] wa; bit oth;
        run_access(1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 4'b1111, lat, rd, wc, wo, wd, wa, oth);
        total++; if (wc != 1) begin bad++; $display("FAIL fstore_we_count: got %0d want 1", wc); end
        total++; if (wo != 1) begin bad++; $display("FAIL fstore_we_cycle: got %0d want 1", wo); end
        total++; if (wa !== 32'h20) begin bad++; $display("FAIL fstore_addr: got %h want 20", wa); end
        total++; if (wd !== 32'hDEADBEEF) begin bad++; $display("FAIL fstore_data: got %h want deadbeef", wd); end
        total++; if (lat != 2) begin bad++; $display("FAIL fstore_latency: got %0d want 2", lat); end
        run_access(1'b1, 1'b0, 32'h20, '0, 4'b0000, lat, rd, wc, wo, wd, wa, oth);
        total++; if (lat != 2) begin bad++; $display("FAIL fetch_latency: got %0d want 2", lat); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL fetch_rdata: got %h want deadbeef", rd); end
        total++; if (oth !== 1'b0) begin bad++; $display("FAIL fetch_d_ack: got %b want 0", oth); end
        total++; if (d_rdata !== 32'h1122CC44) begin bad++; $display("FAIL d_rdata_hold: got %h want 1122cc44", d_rdata); end
    endtask

    task automatic test_zero_strb();
        int lat, wc, wo; logic [31:0] rd, wd; logic [AW-1:0] wa; bit oth;
        run_access(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, lat, rd, wc, wo, wd, wa, oth);
        total++; if (lat != 2) begin bad++; $display("FAIL zstore_latency: got %0d want 2", lat); end
        total++; if (wc != 0) begin bad++; $display("FAIL zstore_mem_we: got %0d cycles want 0", wc); end
        run_access(1'b0, 1'b0, 32'h10, '0, 4'b0000, lat, rd, wc, wo, wd, wa, oth);
        total++; if (rd !== 32'h1122CC44) begin bad++; $display("FAIL zstore_readback: got %h want 1122cc44", rd); end
    endtask

    task automatic test_reset_mid_access();
        int lat, wc, wo, acks; logic [31:0] rd, wd; logic [AW-1:0] wa; bit oth;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'h000000AA; d_strb = 4'b0001;
        @(posedge clk); #1;
        total++; if (mem_address !== 32'h30) begin bad++; $display("FAIL rmid_access_addr: got %h want 30", mem_address); end
        #1 reset = 1'b1;
        #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rmid_mem_we: got %b want 0", mem_we); end
        total++; if (mem_address !== '0) begin bad++; $display("FAIL rmid_mem_address: got %h want 0", mem_address); end
        total++; if (mem_data_in !== '0) begin bad++; $display("FAIL rmid_mem_data_in: got %h want 0", mem_data_in); end
        total++; if (d_rdata !== '0) begin bad++; $display("FAIL rmid_d_rdata: got %h want 0", d_rdata); end
        d_req = 1'b0;
        acks = 0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            if (d_ack || if_ack || mem_we) acks++;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            if (d_ack || if_ack || mem_we) acks++;
        end
        total++; if (acks != 0) begin bad++; $display("FAIL rmid_no_ack: got %0d ack/we cycles want 0", acks); end
        total++; if (mem[12] !== 32'h55667788) begin bad++; $display("FAIL rmid_mem_word: got %h want 55667788", mem[12]); end
        run_access(1'b0, 1'b0, 32'h30, '0, 4'b0000, lat, rd, wc, wo, wd, wa, oth);
        total++; if (lat != 2) begin bad++; $display("FAIL rmid_after_latency: got %0d want 2", lat); end
        total++; if (rd !== 32'h55667788) begin bad++; $display("FAIL rmid_after_rdata: got %h want 55667788", rd); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_load();
        test_partial_store();
        test_full_store();
        test_zero_strb();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, bench did not complete");
        $fatal(1, "watchdog");
    end

endmodule
